// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding imem requests and buffers
// returned words with prediction metadata for decode. FETCH_PERF_CNT_EN adds fetch/redirect counters.
module if_fetch_unit #(
    parameter int                    ADDR_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] BOOT_PC    = '0,
    parameter int                    BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] pc_if,
    input  logic                  jump_if,
    input  logic [ADDR_WIDTH-1:0] pc_target_if,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_resp_valid,
    input  logic [31:0]           imem_resp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [31:0]           id_inst,
    output logic [ADDR_WIDTH-1:0] id_pc,
    output logic                  id_pred_taken,
    output logic [ADDR_WIDTH-1:0] id_pred_target
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [63:0]           perf_fetch_cnt,
    output logic [63:0]           perf_redirect_cnt
`endif
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_RUN, S_WAIT, S_WAIT_KILL} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]   infl_pc_q, infl_pc_d;
    logic                    infl_taken_q, infl_taken_d;
    logic [ADDR_WIDTH-1:0]   infl_target_q, infl_target_d;
    logic [PTR_W-1:0]        head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [31:0]             buf_inst_q   [BUF_DEPTH];
    logic [31:0]             buf_inst_d   [BUF_DEPTH];
    logic [ADDR_WIDTH-1:0]   buf_pc_q     [BUF_DEPTH];
    logic [ADDR_WIDTH-1:0]   buf_pc_d     [BUF_DEPTH];
    logic                    buf_taken_q  [BUF_DEPTH];
    logic                    buf_taken_d  [BUF_DEPTH];
    logic [ADDR_WIDTH-1:0]   buf_target_q [BUF_DEPTH];
    logic [ADDR_WIDTH-1:0]   buf_target_d [BUF_DEPTH];

    logic req_vld, hs, push, pop;

    assign id_valid       = (count_q != '0);
    assign id_inst        = buf_inst_q[head_q];
    assign id_pc          = buf_pc_q[head_q];
    assign id_pred_taken  = buf_taken_q[head_q];
    assign id_pred_target = buf_target_q[head_q];
    assign pc_if          = pc_q;
    assign imem_req_addr  = pc_q;
    assign imem_req_valid = req_vld;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        infl_pc_d     = infl_pc_q;
        infl_taken_d  = infl_taken_q;
        infl_target_d = infl_target_q;
        head_d        = head_q;
        tail_d        = tail_q;
        buf_inst_d    = buf_inst_q;
        buf_pc_d      = buf_pc_q;
        buf_taken_d   = buf_taken_q;
        buf_target_d  = buf_target_q;

        // Only RUN can issue, so the in-flight slot is already reflected in count_q here.
        req_vld = (state_q == S_RUN) && (count_q < CNT_W'(BUF_DEPTH)) && !redirect_valid && !rst;
        hs      = req_vld && imem_req_ready;
        push    = (state_q == S_WAIT) && imem_resp_valid && !redirect_valid;
        pop     = id_valid && id_ready;

        case (state_q)
            S_RUN: begin
                if (hs) begin
                    infl_pc_d     = pc_q;
                    infl_taken_d  = jump_if;
                    infl_target_d = jump_if ? pc_target_if : '0;
                    pc_d          = jump_if ? pc_target_if : pc_q + ADDR_WIDTH'(4);
                    state_d       = S_WAIT;
                end
            end
            S_WAIT, S_WAIT_KILL: begin
                if (imem_resp_valid) state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase

        if (push) begin
            buf_inst_d[tail_q]   = imem_resp_data;
            buf_pc_d[tail_q]     = infl_pc_q;
            buf_taken_d[tail_q]  = infl_taken_q;
            buf_target_d[tail_q] = infl_target_q;
            tail_d               = tail_q + PTR_W'(1);
        end
        if (pop) head_d = head_q + PTR_W'(1);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        // Redirect overrides everything: flush and turn any live fetch into a killed one.
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            if (state_q != S_RUN && !imem_resp_valid) state_d = S_WAIT_KILL;
            else                                      state_d = S_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_RUN;
            pc_q          <= BOOT_PC;
            infl_pc_q     <= '0;
            infl_taken_q  <= 1'b0;
            infl_target_q <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            buf_inst_q    <= '{default: '0};
            buf_pc_q      <= '{default: '0};
            buf_taken_q   <= '{default: '0};
            buf_target_q  <= '{default: '0};
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            infl_pc_q     <= infl_pc_d;
            infl_taken_q  <= infl_taken_d;
            infl_target_q <= infl_target_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            buf_inst_q    <= buf_inst_d;
            buf_pc_q      <= buf_pc_d;
            buf_taken_q   <= buf_taken_d;
            buf_target_q  <= buf_target_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [63:0] perf_fetch_q, perf_fetch_d, perf_redir_q, perf_redir_d;

    always_comb begin
        perf_fetch_d = perf_fetch_q + 64'(push);
        perf_redir_d = perf_redir_q + 64'(redirect_valid);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_q <= '0;
            perf_redir_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_redir_q <= perf_redir_d;
        end
    end

    assign perf_fetch_cnt    = perf_fetch_q;
    assign perf_redirect_cnt = perf_redir_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: imem responder with programmable latency, rule-based predictor.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc_if;
    logic        jump_if;
    logic [63:0] pc_target_if;
    logic        imem_req_valid, imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_valid, id_ready;
    logic [31:0] id_inst;
    logic [63:0] id_pc;
    logic        id_pred_taken;
    logic [63:0] id_pred_target;
`ifdef FETCH_PERF_CNT_EN
    logic [63:0] perf_fetch_cnt, perf_redirect_cnt;
`endif

    if_fetch_unit #(.ADDR_WIDTH(64), .BOOT_PC(64'h1000), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .pc_if(pc_if), .jump_if(jump_if), .pc_target_if(pc_target_if),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .id_valid(id_valid), .id_ready(id_ready),
        .id_inst(id_inst), .id_pc(id_pc), .id_pred_taken(id_pred_taken),
        .id_pred_target(id_pred_target)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_redirect_cnt(perf_redirect_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    int          resp_lat = 1;
    int          hs_cnt = 0;
    logic [63:0] hs_addr;
    logic        jmp_en = 1'b0;
    logic [63:0] jmp_pc = 64'h0;
    logic [63:0] jmp_tgt = 64'h0;

    logic [63:0] got_pc  [8];
    logic [31:0] got_inst[8];
    logic        got_tk  [8];
    logic [63:0] got_tg  [8];
    int          got_cyc [8];
    int          got_n;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    // Memory: one response, resp_lat cycles after each accepted request.
    initial begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        forever begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                hs_addr = imem_req_addr;
                hs_cnt++;
                repeat (resp_lat) @(posedge clk);
                #1;
                imem_resp_valid = 1'b1;
                imem_resp_data  = inst_of(hs_addr);
                @(posedge clk);
                #1;
                imem_resp_valid = 1'b0;
            end
        end
    end

    // Predictor: taken only at jmp_pc; a junk target otherwise must never reach decode.
    initial forever begin
        jump_if      = jmp_en && (pc_if == jmp_pc);
        pc_target_if = jump_if ? jmp_tgt : 64'hDEAD_BEEF_0000_0000;
        @(pc_if or jmp_en or jmp_pc or jmp_tgt);
    end

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        id_ready = 1'b0;
        imem_req_ready = 1'b0;
        jmp_en = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic collect(input int n, input int budget);
        got_n = 0;
        for (int c = 0; c < budget && got_n < n; c++) begin
            @(negedge clk);
            if (id_valid && id_ready) begin
                got_pc[got_n] = id_pc;
                got_inst[got_n] = id_inst;
                got_tk[got_n] = id_pred_taken;
                got_tg[got_n] = id_pred_target;
                got_cyc[got_n] = c;
                got_n++;
            end
        end
    endtask

    task automatic wait_hs(input logic [63:0] a, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 60 && !ok; c++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready && imem_req_addr == a) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_req_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if (pc_if !== 64'h1000) $display("FAIL reset_pc got %h want %h", pc_if, 64'h1000); else n_pass++;
        n_chk++; if (imem_req_valid !== 1'b0) $display("FAIL reset_req_valid got %b want 0", imem_req_valid); else n_pass++;
        n_chk++; if (id_valid !== 1'b0) $display("FAIL reset_id_valid got %b want 0", id_valid); else n_pass++;
        n_chk++; if (id_inst !== 32'h0) $display("FAIL reset_id_inst got %h want 0", id_inst); else n_pass++;
        n_chk++; if (id_pc !== 64'h0) $display("FAIL reset_id_pc got %h want 0", id_pc); else n_pass++;
        n_chk++; if (id_pred_taken !== 1'b0 || id_pred_target !== 64'h0)
            $display("FAIL reset_id_pred got %b/%h want 0/0", id_pred_taken, id_pred_target); else n_pass++;
`ifdef FETCH_PERF_CNT_EN
        n_chk++; if (perf_fetch_cnt !== 64'h0 || perf_redirect_cnt !== 64'h0)
            $display("FAIL reset_perf got %0d/%0d want 0/0", perf_fetch_cnt, perf_redirect_cnt); else n_pass++;
`endif
    endtask

    task automatic test_sequential();
        logic [63:0] e;
        do_reset();
        resp_lat = 1;
        imem_req_ready = 1'b1;
        id_ready = 1'b1;
        collect(3, 40);
        n_chk++; if (got_n !== 3) $display("FAIL seq_count got %0d want 3", got_n); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            e = 64'h1000 + 64'(4 * i);
            n_chk++; if (got_pc[i] !== e) $display("FAIL seq_pc%0d got %h want %h", i, got_pc[i], e); else n_pass++;
            n_chk++; if (got_inst[i] !== inst_of(e)) $display("FAIL seq_inst%0d got %h want %h", i, got_inst[i], inst_of(e)); else n_pass++;
            n_chk++; if (got_tk[i] !== 1'b0 || got_tg[i] !== 64'h0)
                $display("FAIL seq_pred%0d got %b/%h want 0/0", i, got_tk[i], got_tg[i]); else n_pass++;
        end
        n_chk++; if (got_cyc[0] !== 2) $display("FAIL seq_first_latency got %0d want 2", got_cyc[0]); else n_pass++;
        n_chk++; if (got_cyc[1] - got_cyc[0] !== 2 || got_cyc[2] - got_cyc[1] !== 2)
            $display("FAIL seq_spacing got %0d,%0d want 2,2", got_cyc[1] - got_cyc[0], got_cyc[2] - got_cyc[1]); else n_pass++;
    endtask

    task automatic test_jump();
        do_reset();
        resp_lat = 1;
        jmp_pc = 64'h1004;
        jmp_tgt = 64'h2000;
        jmp_en = 1'b1;
        imem_req_ready = 1'b1;
        id_ready = 1'b1;
        collect(3, 40);
        jmp_en = 1'b0;
        n_chk++; if (got_n !== 3) $display("FAIL jump_count got %0d want 3", got_n); else n_pass++;
        n_chk++; if (got_pc[0] !== 64'h1000 || got_pc[1] !== 64'h1004 || got_pc[2] !== 64'h2000)
            $display("FAIL jump_pcs got %h %h %h want 1000 1004 2000", got_pc[0], got_pc[1], got_pc[2]); else n_pass++;
        n_chk++; if (got_tk[1] !== 1'b1 || got_tg[1] !== 64'h2000)
            $display("FAIL jump_pred got %b/%h want 1/2000", got_tk[1], got_tg[1]); else n_pass++;
        n_chk++; if (got_tk[2] !== 1'b0 || got_tg[2] !== 64'h0)
            $display("FAIL jump_after got %b/%h want 0/0", got_tk[2], got_tg[2]); else n_pass++;
        n_chk++; if (got_inst[2] !== inst_of(64'h2000))
            $display("FAIL jump_inst got %h want %h", got_inst[2], inst_of(64'h2000)); else n_pass++;
    endtask

    task automatic test_backpressure();
        int n0;
        do_reset();
        resp_lat = 1;
        imem_req_ready = 1'b1;
        n0 = hs_cnt;
        repeat (12) @(negedge clk);
        n_chk++; if (hs_cnt - n0 !== 2) $display("FAIL bp_requests got %0d want 2", hs_cnt - n0); else n_pass++;
        n_chk++; if (imem_req_valid !== 1'b0) $display("FAIL bp_req_valid got %b want 0", imem_req_valid); else n_pass++;
        n_chk++; if (id_valid !== 1'b1 || id_pc !== 64'h1000)
            $display("FAIL bp_head got %b/%h want 1/1000", id_valid, id_pc); else n_pass++;
        @(posedge clk);
        #1;
        id_ready = 1'b1;
        collect(3, 40);
        n_chk++; if (got_n !== 3 || got_pc[0] !== 64'h1000 || got_pc[1] !== 64'h1004 || got_pc[2] !== 64'h1008)
            $display("FAIL bp_order got n=%0d %h %h %h want 3 1000 1004 1008", got_n, got_pc[0], got_pc[1], got_pc[2]); else n_pass++;
        n_chk++; if (got_cyc[1] - got_cyc[0] !== 1)
            $display("FAIL bp_drain_gap got %0d want 1", got_cyc[1] - got_cyc[0]); else n_pass++;
    endtask

    task automatic test_redirect_wait();
        bit ok;
        do_reset();
        resp_lat = 3;
        imem_req_ready = 1'b1;
        id_ready = 1'b1;
        wait_hs(64'h1008, ok);
        n_chk++; if (ok !== 1'b1) $display("FAIL rw_hs_timeout got 0 want 1"); else n_pass++;
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h3000;
        @(negedge clk);
        n_chk++; if (imem_req_valid !== 1'b0) $display("FAIL rw_req_in_redirect got %b want 0", imem_req_valid); else n_pass++;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        n_chk++; if (pc_if !== 64'h3000) $display("FAIL rw_pc got %h want 3000", pc_if); else n_pass++;
        n_chk++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b0)
            $display("FAIL rw_killwait got id_valid=%b req=%b want 0/0", id_valid, imem_req_valid); else n_pass++;
        collect(1, 40);
        n_chk++; if (got_n !== 1 || got_pc[0] !== 64'h3000 || got_inst[0] !== inst_of(64'h3000))
            $display("FAIL rw_first got n=%0d pc=%h inst=%h want 1 3000 %h", got_n, got_pc[0], got_inst[0], inst_of(64'h3000)); else n_pass++;
        resp_lat = 1;
    endtask

    task automatic test_redirect_resp();
        bit ok;
        do_reset();
        resp_lat = 1;
        imem_req_ready = 1'b1;
        wait_hs(64'h1004, ok);
        n_chk++; if (ok !== 1'b1) $display("FAIL rr_hs_timeout got 0 want 1"); else n_pass++;
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h4000;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        n_chk++; if (id_valid !== 1'b0) $display("FAIL rr_flush got %b want 0", id_valid); else n_pass++;
        n_chk++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h4000)
            $display("FAIL rr_next_req got %b/%h want 1/4000", imem_req_valid, imem_req_addr); else n_pass++;
        @(posedge clk);
        #1;
        id_ready = 1'b1;
        collect(1, 40);
        n_chk++; if (got_n !== 1 || got_pc[0] !== 64'h4000 || got_inst[0] !== inst_of(64'h4000))
            $display("FAIL rr_first got n=%0d pc=%h inst=%h want 1 4000 %h", got_n, got_pc[0], got_inst[0], inst_of(64'h4000)); else n_pass++;
    endtask

    task automatic test_async_reset();
        bit ok;
        do_reset();
        resp_lat = 3;
        imem_req_ready = 1'b1;
        wait_hs(64'h1004, ok);
        n_chk++; if (ok !== 1'b1) $display("FAIL ar_hs_timeout got 0 want 1"); else n_pass++;
        @(posedge clk);
        #1;
        imem_req_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_chk++; if (pc_if !== 64'h1000) $display("FAIL ar_pc got %h want 1000", pc_if); else n_pass++;
        n_chk++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b0)
            $display("FAIL ar_outputs got id_valid=%b req=%b want 0/0", id_valid, imem_req_valid); else n_pass++;
        @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_chk++; if (id_valid !== 1'b0) $display("FAIL ar_stale_resp got id_valid=%b want 0", id_valid); else n_pass++;
        n_chk++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h1000)
            $display("FAIL ar_stall_req got %b/%h want 1/1000", imem_req_valid, imem_req_addr); else n_pass++;
        @(posedge clk);
        #1;
        imem_req_ready = 1'b1;
        id_ready = 1'b1;
        collect(1, 40);
        n_chk++; if (got_n !== 1 || got_pc[0] !== 64'h1000 || got_inst[0] !== inst_of(64'h1000))
            $display("FAIL ar_first got n=%0d pc=%h inst=%h want 1 1000 %h", got_n, got_pc[0], got_inst[0], inst_of(64'h1000)); else n_pass++;
        resp_lat = 1;
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        resp_lat = 1;
        n_chk++; if (perf_fetch_cnt !== 64'h0 || perf_redirect_cnt !== 64'h0)
            $display("FAIL perf_start got %0d/%0d want 0/0", perf_fetch_cnt, perf_redirect_cnt); else n_pass++;
        imem_req_ready = 1'b1;
        id_ready = 1'b1;
        collect(3, 40);
        n_chk++; if (perf_fetch_cnt !== 64'd3 || perf_redirect_cnt !== 64'd0)
            $display("FAIL perf_fetch got %0d/%0d want 3/0", perf_fetch_cnt, perf_redirect_cnt); else n_pass++;
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h5000;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        n_chk++; if (perf_fetch_cnt !== 64'd3 || perf_redirect_cnt !== 64'd1)
            $display("FAIL perf_redirect got %0d/%0d want 3/1", perf_fetch_cnt, perf_redirect_cnt); else n_pass++;
    endtask
`endif

    initial begin
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 64'h0;
        id_ready = 1'b0;
        imem_req_ready = 1'b0;
        test_reset();
        test_sequential();
        test_jump();
        test_backpressure();
        test_redirect_wait();
        test_redirect_resp();
        test_async_reset();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
